// File: rtl/led_gray_serializer.sv
// Backlight gray-frame receiver: captures LED_NUM words into a double-buffered RAM and
// shifts the last complete frame out on sclk/sdo/lat. Optional macro: SDO_PARITY_EN.
module led_gray_serializer #(
    parameter int LED_NUM = 360,
    parameter int CLK_DIV = 4,
    parameter int LAT_W   = 8,
    parameter int GAP_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdbpflag,
    input  logic [9:0]  wtaddr,
    input  logic [15:0] wtdina,
    output logic        sclk,
    output logic        sdo,
    output logic        lat,
    output logic        busy,
    output logic        frame_drop,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_LD    = 3'd2,
        S_SHIFT = 3'd3,
        S_GAP   = 3'd4,
        S_LATCH = 3'd5
    } state_t;

`ifdef SDO_PARITY_EN
    localparam int W_BITS = 17;
`else
    localparam int W_BITS = 16;
`endif
    localparam int HALF = CLK_DIV / 2;
    localparam int IW   = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
    localparam int AW   = $clog2(2 * LED_NUM);
    localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW   = $clog2(W_BITS);
    localparam int CW   = $clog2(((GAP_W > LAT_W) ? GAP_W : LAT_W) + 1);

    // Capture side
    logic          r_flag_d;
    logic          r_armed;
    logic [9:0]    r_exp;
    logic          r_pending;
    logic          r_wr_bank;
    logic          r_rd_bank;
    logic          r_frame_drop;

    // Transmit side
    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_div;
    logic [DW-1:0] w_div_nxt;
    logic [BW-1:0] r_bit;
    logic [IW-1:0] r_idx;
    logic [CW-1:0] r_cnt;
    logic [W_BITS-1:0] r_shreg;
    logic [W_BITS-1:0] w_load;
    logic          r_sclk;
    logic          r_sdo;
    logic          r_lat;
    logic          r_busy;

    logic [15:0]   r_mem [0:2*LED_NUM-1];
    logic [15:0]   r_rd_data;
    logic [AW-1:0] w_wr_addr;
    logic [AW-1:0] w_rd_addr;

    logic w_flag_rise;
    logic w_wr_act;
    logic w_wr_hit;
    logic w_wr_bad;
    logic w_complete;
    logic w_restart_drop;
    logic w_swap;
    logic w_word_end;
    logic w_last_bit;
    logic w_last_word;

`ifdef SDO_PARITY_EN
    assign w_load = {r_rd_data, ^r_rd_data};
`else
    assign w_load = r_rd_data;
`endif

    assign w_flag_rise    = sdbpflag & ~r_flag_d;
    assign w_wr_act       = r_armed && !w_flag_rise && (wtaddr != 10'd0);
    assign w_wr_hit       = w_wr_act && (wtaddr == r_exp);
    assign w_wr_bad       = w_wr_act && (wtaddr != r_exp);
    assign w_complete     = w_wr_hit && (r_exp == 10'(LED_NUM));
    assign w_restart_drop = w_flag_rise && r_armed && (r_exp > 10'd1);
    // A frame completing this cycle defers the swap by one cycle.
    assign w_swap         = (r_state == S_IDLE) && r_pending && !w_complete;

    assign w_wr_addr = AW'(r_wr_bank ? LED_NUM : 0) + AW'(r_exp - 10'd1);
    assign w_rd_addr = AW'(r_rd_bank ? LED_NUM : 0) + AW'(r_idx);

    assign w_word_end  = (r_state == S_SHIFT) && (r_div == DW'(CLK_DIV - 1));
    assign w_last_bit  = (r_bit == '0);
    assign w_last_word = (r_idx == IW'(LED_NUM - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_d     <= 1'b0;
            r_armed      <= 1'b0;
            r_exp        <= 10'd1;
            r_pending    <= 1'b0;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b1;
            r_frame_drop <= 1'b0;
        end else begin
            r_flag_d     <= sdbpflag;
            r_frame_drop <= w_wr_bad | w_restart_drop;
            if (w_flag_rise) begin
                r_armed <= 1'b1;
                r_exp   <= 10'd1;
            end else if (w_wr_hit) begin
                r_exp <= r_exp + 10'd1;
                if (w_complete) r_armed <= 1'b0;
            end else if (w_wr_bad) begin
                r_armed <= 1'b0;
            end
            if (w_complete)  r_pending <= 1'b1;
            else if (w_swap) r_pending <= 1'b0;
            if (w_swap) begin
                r_wr_bank <= r_rd_bank;
                r_rd_bank <= r_wr_bank;
            end
        end
    end

    // Frame RAM: contents need no reset, only the bank pointers do.
    always_ff @(posedge clk) begin
        if (w_wr_hit) r_mem[w_wr_addr] <= wtdina;
        if (r_state == S_RD) r_rd_data <= r_mem[w_rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = '0;
        case (r_state)
            S_IDLE:  if (w_swap) w_state_nxt = S_RD;
            S_RD:    w_state_nxt = S_LD;
            S_LD:    w_state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (!w_word_end) w_div_nxt = r_div + DW'(1);
                if (w_word_end && w_last_bit) w_state_nxt = w_last_word ? S_GAP : S_RD;
            end
            S_GAP:   if (r_cnt == CW'(GAP_W - 1)) w_state_nxt = S_LATCH;
            S_LATCH: if (r_cnt == CW'(LAT_W - 1)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_bit   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_shreg <= '0;
            r_sclk  <= 1'b0;
            r_sdo   <= 1'b0;
            r_lat   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_div  <= w_div_nxt;
            // sclk is low for the first half of each bit period, high for the second.
            r_sclk <= (w_state_nxt == S_SHIFT) && (w_div_nxt >= DW'(HALF));
            r_lat  <= (w_state_nxt == S_LATCH);
            if (((r_state == S_GAP) || (r_state == S_LATCH)) && (w_state_nxt == r_state))
                r_cnt <= r_cnt + CW'(1);
            else
                r_cnt <= '0;
            case (r_state)
                S_IDLE: r_idx <= '0;
                S_LD: begin
                    r_shreg <= w_load;
                    r_bit   <= BW'(W_BITS - 1);
                    r_sdo   <= w_load[W_BITS-1];
                    r_busy  <= 1'b1;
                end
                S_SHIFT: begin
                    if (w_word_end) begin
                        if (!w_last_bit) begin
                            r_shreg <= r_shreg << 1;
                            r_sdo   <= r_shreg[W_BITS-2];
                            r_bit   <= r_bit - BW'(1);
                        end else if (w_last_word) begin
                            r_sdo <= 1'b0;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
                S_LATCH: if (w_state_nxt == S_IDLE) r_busy <= 1'b0;
                default: ;
            endcase
        end
    end

    assign sclk        = r_sclk;
    assign sdo         = r_sdo;
    assign lat         = r_lat;
    assign busy        = r_busy;
    assign frame_drop  = r_frame_drop;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_led_gray_serializer.sv
// Bench for led_gray_serializer: directed frames, expected words queued at capture
// time and popped by a serial-bus monitor.
module tb_led_gray_serializer;
  localparam int LED_NUM = 12;
  localparam int CLK_DIV = 4;
  localparam int LAT_W   = 8;
  localparam int GAP_W   = 4;
`ifdef SDO_PARITY_EN
  localparam int WB = 17;
`else
  localparam int WB = 16;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sdbpflag = 1'b0;
  logic [9:0]  wtaddr = '0;
  logic [15:0] wtdina = '0;
  logic        sclk, sdo, lat, busy, frame_drop;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int sclk_rises = 0;
  int lat_falls = 0;
  int drops = 0;

  logic [WB-1:0] exp_q[$];

  led_gray_serializer #(
    .LED_NUM(LED_NUM), .CLK_DIV(CLK_DIV), .LAT_W(LAT_W), .GAP_W(GAP_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sdbpflag(sdbpflag), .wtaddr(wtaddr), .wtdina(wtdina),
    .sclk(sclk), .sdo(sdo), .lat(lat), .busy(busy), .frame_drop(frame_drop),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] word_of(input int pat, input int i);
    case (pat)
      0: return 16'(i);
      1: return 16'h0000;
      2: return 16'hFFFF;
      3: return 16'h8001 ^ 16'(i << 4);
      4: return 16'h5A5A ^ 16'(i);
      5: return (i % 2 == 1) ? 16'h0003 : 16'h0001;
      default: return 16'hC3C3 + 16'(i);
    endcase
  endfunction

  function automatic logic [WB-1:0] exp_of(input logic [15:0] w);
`ifdef SDO_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  // driver tasks
  task automatic send_frame(input int pat, input bit push);
    @(posedge clk); #1;
    sdbpflag = 1'b1;
    wtaddr = '0;
    for (int i = 0; i < LED_NUM; i++) begin
      @(posedge clk); #1;
      sdbpflag = 1'b0;
      wtaddr = 10'(i + 1);
      wtdina = word_of(pat, i);
      if (push) exp_q.push_back(exp_of(word_of(pat, i)));
    end
    @(posedge clk); #1;
    wtaddr = '0;
  endtask

  task automatic partial_frame(input int n, input int bad_addr);
    @(posedge clk); #1;
    sdbpflag = 1'b1;
    wtaddr = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      sdbpflag = 1'b0;
      wtaddr = 10'(i + 1);
      wtdina = 16'hDEAD;
    end
    if (bad_addr != 0) begin
      @(posedge clk); #1;
      wtaddr = 10'(bad_addr);
    end
    @(posedge clk); #1;
    sdbpflag = 1'b0;
    wtaddr = '0;
  endtask

  task automatic wait_lat(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (lat_falls < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk(name, 32'(lat_falls >= n), 32'd1);
  endtask

  // monitor + scoreboard
  logic          prev_sclk, prev_sdo, prev_lat, prev_busy;
  logic [WB-1:0] shv;
  logic [WB-1:0] want;
  int            bit_n, frame_rises, lat_w;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sclk = 1'b0; prev_sdo = 1'b0; prev_lat = 1'b0; prev_busy = 1'b0;
      shv = '0; bit_n = 0; frame_rises = 0; lat_w = 0;
    end else begin
      if (sclk && prev_sclk) chk("sdo_stable_while_sclk_high", 32'(sdo), 32'(prev_sdo));
      if (sclk && !prev_sclk) begin
        sclk_rises++;
        frame_rises++;
        shv = {shv[WB-2:0], sdo};
        bit_n++;
        if (bit_n == WB) begin
          bit_n = 0;
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 32'(shv), 32'hFFFF_FFFF);
          end else begin
            want = exp_q.pop_front();
            chk("word", 32'(shv), 32'(want));
          end
        end
      end
      if (lat) lat_w++;
      if (!lat && prev_lat) begin
        lat_falls++;
        chk("lat_width", 32'(lat_w), 32'(LAT_W));
        chk("busy_falls_with_lat", {30'd0, prev_busy, busy}, 32'b10);
        chk("sclk_rises_per_frame", 32'(frame_rises), 32'(LED_NUM * WB));
        lat_w = 0;
        frame_rises = 0;
      end
      if (frame_drop) drops++;
      prev_sclk = sclk; prev_sdo = sdo; prev_lat = lat; prev_busy = busy;
    end
  end

  initial begin : stim
    int r0, l0, d0, k;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_sdo", 32'(sdo), 0);
    chk("rst_lat", 32'(lat), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_drop", 32'(frame_drop), 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // T2 single frame, word k = k
    send_frame(0, 1'b1);
    wait_lat(1, 3000, "t2_frame_done");

    // T3 out-of-order write: drop, no transmission, then good frame
    d0 = drops; r0 = sclk_rises;
    partial_frame(10, 12);
    repeat (200) @(posedge clk);
    chk("t3_drop_pulse", 32'(drops - d0), 32'd1);
    chk("t3_no_tx", 32'(sclk_rises), 32'(r0));
    send_frame(3, 1'b1);
    wait_lat(2, 3000, "t3_good_frame_done");

    // T4 back-to-back: B completes during A
    send_frame(1, 1'b1);
    repeat (60) @(posedge clk);
    send_frame(2, 1'b1);
    wait_lat(4, 5000, "t4_a_then_b");
    // C completes before B's swap and replaces it
    send_frame(4, 1'b1);
    repeat (60) @(posedge clk);
    send_frame(6, 1'b0);
    repeat (5) @(posedge clk);
    send_frame(2, 1'b1);
    wait_lat(6, 5000, "t4_latest_wins");
    repeat (300) @(posedge clk);
    chk("t4_no_extra_frame", 32'(lat_falls), 32'd6);

    // T5 restart mid-frame
    d0 = drops;
    partial_frame(5, 0);
    send_frame(4, 1'b1);
    repeat (3) @(posedge clk);
    chk("t5_restart_drop", 32'(drops - d0), 32'd1);
    wait_lat(7, 3000, "t5_frame_done");

    // T6 parity pattern (plain 16-bit words without the macro)
    send_frame(5, 1'b1);
    wait_lat(8, 3000, "t6_frame_done");
    chk("queue_drained", 32'(exp_q.size()), 0);

    // T1 reset mid-SHIFT
    r0 = sclk_rises;
    send_frame(0, 1'b1);
    k = 0;
    while (sclk_rises < r0 + 20 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    chk("t1_reached_shift", 32'(sclk_rises >= r0 + 20), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t1_sclk", 32'(sclk), 0);
    chk("t1_sdo", 32'(sdo), 0);
    chk("t1_lat", 32'(lat), 0);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_frame_drop", 32'(frame_drop), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    r0 = sclk_rises; l0 = lat_falls;
    repeat (1000) @(posedge clk);
    chk("t1_no_sclk_after_reset", 32'(sclk_rises), 32'(r0));
    chk("t1_no_lat_after_reset", 32'(lat_falls), 32'(l0));
    send_frame(3, 1'b1);
    wait_lat(l0 + 1, 3000, "t1_recovery_frame");
    chk("final_queue_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
